// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings are visible on hazard_state, so they are fixed here.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_FLUSH  = 2'd1,
    HZ_FREEZE = 2'd2
  } hz_state_t;

  localparam logic [4:0] X0_IDX = 5'd0;

  // A load in EX feeding a source register that ID actually reads; x0 never stalls.
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return mem_read && (rd != X0_IDX) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the hazard controller (master) and the pipeline datapath (slave).
// Carries hazard-detection inputs, write/flush enables and the bubble select.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             use_rs1_ID;
  logic             use_rs2_ID;
  logic             MemRead_EX;
  logic [4:0]       rd_EX;
  logic             branch_taken_EX;
  logic             mem_stall;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Write;
  logic             nopMux_Select;
  logic [1:0]       hazard_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, MemRead_EX, rd_EX,
           branch_taken_EX, mem_stall,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, nopMux_Select,
           hazard_state, stall_cnt, flush_cnt
  );

  modport slave (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, MemRead_EX, rd_EX,
           branch_taken_EX, mem_stall,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, nopMux_Select,
           hazard_state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flush bubbles and
// data-memory freeze, driving PC/IF-ID/ID-EX enables and the ID/EX bubble mux.
//
// state     | meaning
// HZ_RUN    | normal issue; load-use stalls handled in place
// HZ_FLUSH  | inserting post-branch bubbles, fcnt = bubbles still owed
// HZ_FREEZE | memory stall; saved_state/fcnt restored on release
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.master hz
);

  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  hz_state_t  state, state_n;
  hz_state_t  saved_state, saved_state_n;
  hz_state_t  eff_state;
  logic [1:0] fcnt, fcnt_n;
  logic       lu;
  logic       stall_inc, flush_inc;
  logic       pc_we, ifid_we, idex_we, ifid_flush, nop_sel;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign lu = load_use(hz.MemRead_EX, hz.rd_EX, hz.rs1_ID, hz.rs2_ID,
                       hz.use_rs1_ID, hz.use_rs2_ID);

  // The release cycle out of FREEZE already behaves as the saved state.
  assign eff_state = (state == HZ_FREEZE) ? saved_state : state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HZ_RUN;
      saved_state <= HZ_RUN;
      fcnt        <= 2'd0;
    end else begin
      state       <= state_n;
      saved_state <= saved_state_n;
      fcnt        <= fcnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    saved_state_n = saved_state;
    fcnt_n        = fcnt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    idex_we       = 1'b1;
    ifid_flush    = 1'b0;
    nop_sel       = 1'b0;

    if (hz.mem_stall) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      state_n = HZ_FREEZE;
      if (state != HZ_FREEZE) begin
        saved_state_n = state;
      end
    end else if (hz.branch_taken_EX) begin
      ifid_flush = 1'b1;
      nop_sel    = 1'b1;
      flush_inc  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = HZ_FLUSH;
        fcnt_n  = FCNT_INIT;
      end else begin
        state_n = HZ_RUN;
        fcnt_n  = 2'd0;
      end
    end else if (eff_state == HZ_FLUSH) begin
      ifid_flush = 1'b1;
      nop_sel    = 1'b1;
      fcnt_n     = fcnt - 2'd1;
      state_n    = (fcnt == 2'd1) ? HZ_RUN : HZ_FLUSH;
    end else if (lu) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      nop_sel   = 1'b1;
      stall_inc = 1'b1;
      state_n   = HZ_RUN;
    end else begin
      state_n = HZ_RUN;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .q     (stall_q)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .q     (flush_q)
  );

  // Reset forces a bubble with every enable off, independent of the clock.
  assign hz.PCWrite       = reset ? 1'b0 : pc_we;
  assign hz.IFID_Write    = reset ? 1'b0 : ifid_we;
  assign hz.IDEX_Write    = reset ? 1'b0 : idex_we;
  assign hz.IFID_Flush    = reset ? 1'b0 : ifid_flush;
  assign hz.nopMux_Select = reset ? 1'b1 : nop_sel;
  assign hz.hazard_state  = state;
  assign hz.stall_cnt     = stall_q;
  assign hz.flush_cnt     = flush_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Vector-table bench for hazard_unit: default build plus a CNT_W=2 build driven
// with identical stimulus to exercise counter saturation.
module tb_hazard_unit;

  logic clk;
  logic reset;

  hazard_unit_if #(.CNT_W(16)) hz  ();
  hazard_unit_if #(.CNT_W(2))  hz2 ();

  hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  hazard_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .hz    (hz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out = {PCWrite, IFID_Write, IDEX_Write, IFID_Flush, nopMux_Select}
  localparam logic [4:0] O_RUN = 5'b11100;
  localparam logic [4:0] O_STL = 5'b00101;
  localparam logic [4:0] O_FLS = 5'b11111;
  localparam logic [4:0] O_FRZ = 5'b00000;
  localparam logic [4:0] O_RST = 5'b00001;
  localparam logic [1:0] ST_ANY = 2'd3;

  typedef struct {
    logic       rst, ms, br, mr;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [4:0] out;
    logic [1:0] st;
    int         sc, fc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic rst, logic ms, logic br, logic mr,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic [4:0] out,
                              logic [1:0] st, int sc, int fc);
    vec_t v;
    v.rst = rst; v.ms = ms; v.br = br; v.mr = mr;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.out = out; v.st = st; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, expv);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    hz.mem_stall  = v.ms;  hz2.mem_stall  = v.ms;
    hz.branch_taken_EX = v.br; hz2.branch_taken_EX = v.br;
    hz.MemRead_EX = v.mr;  hz2.MemRead_EX = v.mr;
    hz.rd_EX      = v.rd;  hz2.rd_EX      = v.rd;
    hz.rs1_ID     = v.rs1; hz2.rs1_ID     = v.rs1;
    hz.rs2_ID     = v.rs2; hz2.rs2_ID     = v.rs2;
    hz.use_rs1_ID = v.u1;  hz2.use_rs1_ID = v.u1;
    hz.use_rs2_ID = v.u2;  hz2.use_rs2_ID = v.u2;
  endtask

  function automatic logic [4:0] outs();
    return {hz.PCWrite, hz.IFID_Write, hz.IDEX_Write, hz.IFID_Flush, hz.nopMux_Select};
  endfunction

  task automatic compare(input int idx);
    vec_t e;
    e = exp_q.pop_front();
    check("ctrl_outs", idx, int'(outs()), int'(e.out));
    if (e.st != ST_ANY) check("hazard_state", idx, int'(hz.hazard_state), int'(e.st));
    check("stall_cnt", idx, int'(hz.stall_cnt), e.sc);
    check("flush_cnt", idx, int'(hz.flush_cnt), e.fc);
    check("sat_stall_cnt", idx, int'(hz2.stall_cnt), (e.sc > 3) ? 3 : e.sc);
    check("sat_flush_cnt", idx, int'(hz2.flush_cnt), (e.fc > 3) ? 3 : e.fc);
  endtask

  vec_t idle_v;

  initial begin
    reset = 1'b1;
    idle_v = mk(0,0,0,0, 5'd0,5'd0,5'd0, 0,0, O_RUN, 2'd0, 0, 0);
    drive(mk(1,0,0,0, 5'd0,5'd0,5'd0, 0,0, O_RST, 2'd0, 0, 0));

    //          rst ms br mr  rd     rs1    rs2   u1 u2  out    st  sc fc
    vecs.push_back(mk(1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RST, 2'd0, 0, 0)); // 0
    vecs.push_back(mk(1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RST, 2'd0, 0, 0));
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 0, 0));
    vecs.push_back(mk(0,0,0,1, 5'd5, 5'd5, 5'd1, 1,1, O_STL, 2'd0, 0, 0)); // lw x5 / add x6,x5,x1
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd6, 5'd0, 1,0, O_RUN, 2'd0, 1, 0));
    vecs.push_back(mk(0,0,0,1, 5'd0, 5'd0, 5'd0, 1,1, O_RUN, 2'd0, 1, 0)); // rd=x0
    vecs.push_back(mk(0,0,0,1, 5'd7, 5'd3, 5'd7, 1,0, O_RUN, 2'd0, 1, 0)); // rs2 unused
    vecs.push_back(mk(0,0,0,1, 5'd9, 5'd2, 5'd9, 1,1, O_STL, 2'd0, 1, 0)); // rs2 hazard
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 2, 0));
    vecs.push_back(mk(0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, 2'd0, 2, 0)); // branch
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, 2'd1, 2, 1)); // 10
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 2, 1));
    vecs.push_back(mk(0,0,1,1, 5'd4, 5'd4, 5'd0, 1,0, O_FLS, 2'd0, 2, 1)); // branch + lu
    vecs.push_back(mk(0,0,0,1, 5'd4, 5'd4, 5'd0, 1,0, O_FLS, 2'd1, 2, 2)); // lu ignored
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 2, 2));
    vecs.push_back(mk(0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, 2'd0, 2, 2));
    vecs.push_back(mk(0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_FRZ, 2'd1, 2, 3)); // freeze in FLUSH
    vecs.push_back(mk(0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_FRZ, 2'd2, 2, 3));
    vecs.push_back(mk(0,1,0,1, 5'd8, 5'd8, 5'd0, 1,0, O_FRZ, 2'd2, 2, 3));
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, ST_ANY, 2, 3)); // owed bubble
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 2, 3)); // 20
    vecs.push_back(mk(0,1,0,1, 5'd3, 5'd3, 5'd0, 1,0, O_FRZ, 2'd0, 2, 3)); // freeze in RUN
    vecs.push_back(mk(0,0,0,1, 5'd3, 5'd3, 5'd0, 1,0, O_STL, ST_ANY, 2, 3));
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 3, 3));
    vecs.push_back(mk(0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, 2'd0, 3, 3));
    vecs.push_back(mk(0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, 2'd1, 3, 4)); // restart
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, 2'd1, 3, 5));
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 3, 5));
    vecs.push_back(mk(0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, O_FLS, 2'd0, 3, 5));
    vecs.push_back(mk(1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RST, 2'd0, 0, 0)); // reset mid-FLUSH
    vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, 0, 0)); // 30
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(mk(0,0,0,1, 5'd5, 5'd5, 5'd0, 1,0, O_STL, 2'd0, k, 0));
      vecs.push_back(mk(0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, O_RUN, 2'd0, k+1, 0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      compare(i);
    end

    // Asynchronous reset while frozen mid-FLUSH: takes effect before any edge.
    @(posedge clk); #1;
    drive(mk(0,0,1,0, 5'd0,5'd0,5'd0, 0,0, O_FLS, 2'd0, 0, 0));
    @(posedge clk); #1;
    drive(mk(0,1,0,0, 5'd0,5'd0,5'd0, 0,0, O_FRZ, 2'd1, 0, 1));
    @(posedge clk); #1;
    check("freeze_state", 100, int'(hz.hazard_state), 2);
    check("freeze_outs", 100, int'(outs()), int'(O_FRZ));
    check("freeze_flush_cnt", 100, int'(hz.flush_cnt), 1);
    reset = 1'b1;
    #1;
    check("async_rst_state", 101, int'(hz.hazard_state), 0);
    check("async_rst_outs", 101, int'(outs()), int'(O_RST));
    check("async_rst_flush_cnt", 101, int'(hz.flush_cnt), 0);
    @(posedge clk); #1;
    drive(idle_v);
    @(negedge clk);
    check("post_rst_outs", 102, int'(outs()), int'(O_RUN));
    check("post_rst_state", 102, int'(hz.hazard_state), 0);
    check("post_rst_stall_cnt", 102, int'(hz.stall_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
